// File: rtl/rv32_tb_pkg.sv
// Shared types and constants for the RV32 fetch-side memory model.
// Used by the instruction-memory responder and its LFSR.
package rv32_tb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_state_t;

  localparam logic [7:0] LFSR8_TAPS = 8'hB8;
  localparam logic [7:0] LFSR8_SEED = 8'hA5;

endpackage

// File: rtl/rv32_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Free-running; advances every cycle after reset.
module rv32_lfsr8
  import rv32_tb_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR8_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] state
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR8_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/rv32_imem_responder.sv
// Memory side of the core fetch/stall interface: programmable
// wait states, registered read data, misalign/range errors.
module rv32_imem_responder
  import rv32_tb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [7:0]  LFSR_SEED = LFSR8_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [3:0]  cfg_wait,
  input  logic        cfg_random,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] err_count
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  typedef logic [AW-1:0] idx_t;

  imem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  idx_t        idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [15:0] errc_q, errc_d;
  logic [7:0]  lfsr;
  logic [31:0] mem [MEM_WORDS];

  rv32_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (lfsr)
  );

  logic       req_err;
  logic [3:0] req_wait;
  idx_t       req_idx;
  logic       ld_ok;
  idx_t       ld_idx;
  logic       unused_bits;

  assign req_idx  = req_addr[AW+1:2];
  assign req_err  = (req_addr[1:0] != 2'b00) ||
                    ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  assign req_wait = cfg_random ? (lfsr[3:0] & cfg_wait) : cfg_wait;
  assign ld_idx   = ld_addr[AW+1:2];
  assign ld_ok    = ld_en &&
                    ({2'b00, ld_addr[31:2]} < 32'(MEM_WORDS));
  assign unused_bits = ^{ld_addr[1:0], lfsr[7:4]};

  logic rd_go;
  logic rd_err;
  idx_t rd_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rd_go   = 1'b0;
    rd_err  = 1'b0;
    rd_idx  = idx_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d  = req_idx;
          rd_idx = req_idx;
          if (req_err || req_wait == 4'd0) begin
            state_d = RESP;
            rd_go   = 1'b1;
            rd_err  = req_err;
          end else begin
            state_d = WAIT;
            cnt_d   = req_wait;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rd_go   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read happens on the edge into RESP; same-edge preload sees old word.
  always_comb begin
    data_d = data_q;
    err_d  = err_q;
    errc_d = errc_q;
    if (rd_go) begin
      err_d  = rd_err;
      data_d = rd_err ? 32'h0 : mem[rd_idx];
      if (rd_err && errc_q != 16'hFFFF) errc_d = errc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      errc_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_idx] <= ld_data;
  end

  assign stall     = (state_q == IDLE && req_valid) || state_q == WAIT;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign err_count = errc_q;

endmodule

// File: doc/rv32_imem_responder.md
# rv32_imem_responder

Instruction-fetch responder that plays the memory side of the RV32 core's fetch/stall interface. It accepts fetch requests, holds the core in stall for a programmable number of wait states, and then returns the instruction word or an error. Misaligned and out-of-range fetches are flagged. It is the driving counterpart to the core-side assertion monitor, which checks that PC holds while `stall` is high and that PC stays word-aligned. It lives in the testbench/SoC memory layer beside the core.

## Interface
- `MEM_WORDS`, 1024: instruction memory depth in 32-bit words.
- `LFSR_SEED`, 8'hA5: reset value of the wait-state LFSR.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: core requests a fetch this cycle.
- `req_addr` in 32: byte address of the fetch.
- `cfg_wait` in 4: wait-state count (or mask, in random mode), sampled at acceptance.
- `cfg_random` in 1: 1 means wait = `lfsr[3:0] & cfg_wait`, sampled at acceptance.
- `ld_en` in 1: preload write enable.
- `ld_addr` in 32: preload byte address; bits [1:0] ignored.
- `ld_data` in 32: preload word.
- `stall` out 1: core must hold PC and fetch state.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_data` out 32: instruction word; 0 on error.
- `rsp_err` out 1: misaligned or out-of-range fetch; valid with `rsp_valid`.
- `err_count` out 16: saturating count of error responses.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE:**
  - If `req_valid` is high, latch `req_addr` and compute the wait count W:
    - W = `cfg_wait` when `cfg_random` = 0.
    - W = `lfsr[3:0] & cfg_wait` when `cfg_random` = 1.
  - Error request: `req_addr[1:0]` != 0, or word index `req_addr[31:2]` >= `MEM_WORDS`. Go straight to RESP with the error latched; W is ignored.
  - Good request with W = 0: go to RESP.
  - Good request with W > 0: go to WAIT with counter = W.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter is 1, go to RESP.
  - `req_*` inputs are ignored while in WAIT.
- **RESP:**
  - `rsp_valid` = 1 for exactly one cycle, then return to IDLE.
  - A new request is accepted in the following IDLE cycle, not in RESP.
- **`stall`:** `(state==IDLE && req_valid) || state==WAIT`. This term is combinational from `req_valid`. `stall` is 0 in RESP, where the core consumes `rsp_data` and advances PC.
- **Memory read:** performed on the transition into RESP; `rsp_data` is registered.
  - An `ld_en` write in that same cycle to the same word returns the old word.
  - Writes in earlier cycles are visible.
- **Preload:** `ld_en` writes `mem[ld_addr[31:2]]` in any state. Out-of-range preload addresses are dropped silently.
- **LFSR:** 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It advances every cycle after reset, regardless of state.
- **`err_count`:** increments on each RESP with `rsp_err` = 1 and saturates at 16'hFFFF.

## Timing
- **Latency:** a request accepted in IDLE at cycle T gives `rsp_valid` at T+1+W.
  - Error responses come at T+1.
  - Maximum throughput is one fetch per 2+W cycles.
- **`stall` duration:** high from T through T+W, low at T+1+W.
- **Reset values:**
  - state IDLE.
  - `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0, `err_count` 0.
  - LFSR = `LFSR_SEED`, wait counter 0.
  - Memory contents are not reset.
- **Reset mid-WAIT or mid-RESP:** the transaction is aborted and no response is emitted. The first accepted request after release is fresh.
- **Request inputs during WAIT:** `req_addr` and `cfg_*` changes after acceptance have no effect on the in-flight transaction.

## Structure
- Shared package `rv32_tb_pkg`:
  - state enum `imem_state_t` (IDLE, WAIT, RESP).
  - LFSR tap mask constant `LFSR8_TAPS = 8'hB8`.
  - Default seed constant.
- One sub-module, `rv32_lfsr8`: clock, async reset, seed parameter, 8-bit state output.
- Memory is an inferred array in the top module, with one write port (`ld`) and one read port.

## Test plan
- Preload word 0x10 = 32'h00500093. Request addr 0x40 with `cfg_wait` = 0. Expect `stall` for 1 cycle, then `rsp_valid` with data 32'h00500093 and `rsp_err` 0 at T+1.
- `cfg_wait` = 3 and `req_addr` = 0x40 held. Expect `stall` high for 4 cycles and `rsp_valid` at T+4. `req_addr` changing to 0x44 during WAIT does not alter the data.
- `req_addr` = 0x42. Expect `rsp_err` = 1 and `rsp_data` = 0 at T+1, and `err_count` = 1.
- `MEM_WORDS` = 1024 with `req_addr` = 0x1000. Expect an out-of-range error at T+1.
- `cfg_random` = 1, `cfg_wait` = 4'hF after reset, with back-to-back requests. Wait counts must match a reference model of the LFSR from seed A5, and PC-hold checks must pass throughout.
- Assert `rst_n` low during WAIT with `cfg_wait` = 5. After release, no `rsp_valid` from the aborted request; `stall` = 0 until a new `req_valid`.
